// File: rtl/fp_div_pkg.sv
// Definitions shared by the Newton-Raphson divider and its operand feeder.
package fp_div_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] FP_SINGLE_2    = 32'h4000_0000;
    localparam logic [WIDTH-1:0] FP_SINGLE_QNAN = 32'hFFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/fp_operand_fifo.sv
// Circular FIFO of operand pairs; exposes the head entry and the one after it
// so the feeder can chain pairs without an idle cycle.
module fp_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DW-1:0]              wdata_i,
    output logic [DW-1:0]              head_o,
    output logic [DW-1:0]              next_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q, head_nxt;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign head_nxt = head_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + AW'(1);
            if (do_pop)  head_q <= head_nxt;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

    assign head_o  = mem_q[head_q];
    assign next_o  = mem_q[head_nxt];
    assign count_o = count_q;

endmodule

// File: rtl/fp_div_operand_feeder.sv
// Queues dividend/divisor pairs and hands them to the divider as an A transfer
// followed by a B transfer over its strobe/ack operand ports.
//
// state     | meaning
// ST_IDLE   | no pair in flight; waits for the FIFO to become non-empty
// ST_SEND_A | out_a_stb high, waiting for input_a_ack
// ST_SEND_B | out_b_stb high, waiting for input_b_ack; pop on transfer
module fp_div_operand_feeder
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = fp_div_pkg::WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_a,
    output logic                   out_a_stb,
    input  logic                   out_a_ack,
    output logic [WIDTH-1:0]       out_b,
    output logic                   out_b_stb,
    input  logic                   out_b_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            pairs_sent
);
    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_e      state_q, state_d;
    logic [WIDTH-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic               a_stb_q, a_stb_d, b_stb_q, b_stb_d;
    logic [15:0]        sent_q, sent_d;
    logic               pop, full, empty;
    logic [2*WIDTH-1:0] head_pair, next_pair;
    logic [CW-1:0]      fifo_count;

    fp_operand_fifo #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop),
        .wdata_i ({in_a, in_b}),
        .head_o  (head_pair),
        .next_o  (next_pair),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_a_q <= '0;
            out_b_q <= '0;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            a_stb_q <= a_stb_d;
            b_stb_q <= b_stb_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        a_stb_d = a_stb_q;
        b_stb_d = b_stb_q;
        sent_d  = sent_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    {out_a_d, out_b_d} = head_pair;
                    a_stb_d = 1'b1;
                    state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (a_stb_q && out_a_ack) begin
                    a_stb_d = 1'b0;
                    b_stb_d = 1'b1;
                    state_d = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                if (b_stb_q && out_b_ack) begin
                    b_stb_d = 1'b0;
                    pop     = 1'b1;
                    sent_d  = sent_q + 16'd1;
                    // A pair pushed this same cycle is not chained; IDLE picks it up.
                    if (fifo_count != CW'(1)) begin
                        {out_a_d, out_b_d} = next_pair;
                        a_stb_d = 1'b1;
                        state_d = ST_SEND_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = !full;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_a_stb  = a_stb_q;
    assign out_b_stb  = b_stb_q;
    assign count      = fifo_count;
    assign pairs_sent = sent_q;

endmodule

// File: tb/tb_fp_div_operand_feeder.sv
// Directed bench for the divider operand feeder: latency, fill/backpressure,
// ordering under random acks, push+pop at once, and mid-operation reset.
module tb_fp_div_operand_feeder;

    logic        clk;
    logic        rst;
    logic [31:0] in_a, in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_a, out_b;
    logic        out_a_stb, out_a_ack, out_b_stb, out_b_ack;
    logic [2:0]  count;
    logic [15:0] pairs_sent;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    fp_div_operand_feeder #(.DEPTH(4), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_a      (out_a),
        .out_a_stb  (out_a_stb),
        .out_a_ack  (out_a_ack),
        .out_b      (out_b),
        .out_b_stb  (out_b_stb),
        .out_b_ack  (out_b_ack),
        .count      (count),
        .pairs_sent (pairs_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Delivers n queued pairs with random acks, checking order, strobe exclusivity and hold.
    task automatic drain(input int n);
        int got = 0;
        int cyc = 0;
        logic [31:0] pa, pb;
        logic pas, pbs;
        while (got < n && cyc < 300) begin
            out_a_ack = 1'($urandom_range(0, 1));
            out_b_ack = 1'($urandom_range(0, 1));
            #1;
            if (out_a_stb && out_a_ack) chk("order_a", out_a, exp_a[0]);
            if (out_b_stb && out_b_ack) begin
                chk("order_b", out_b, exp_b[0]);
                void'(exp_a.pop_front());
                void'(exp_b.pop_front());
                got++;
            end
            pa = out_a; pb = out_b; pas = out_a_stb; pbs = out_b_stb;
            step();
            cyc++;
            chk("stb_excl", 32'(out_a_stb & out_b_stb), 32'd0);
            if (pas && out_a_stb) chk("hold_a", out_a, pa);
            if (pbs && out_b_stb) chk("hold_b", out_b, pb);
        end
        chk("drain_done", 32'(got), 32'(n));
        out_a_ack = 1'b0;
        out_b_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0;
        out_a_ack = 1'b0; out_b_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_a_stb", 32'(out_a_stb), 32'd0);
        chk("rst_b_stb", 32'(out_b_stb), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_sent", 32'(pairs_sent), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Single pair 6.0 / 2.0 with acks held high
        out_a_ack = 1'b1; out_b_ack = 1'b1;
        in_a = 32'h40C0_0000; in_b = 32'h4000_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_cnt_e0", 32'(count), 32'd1);
        chk("lat_astb_e0", 32'(out_a_stb), 32'd0);
        step();
        chk("lat_astb_e1", 32'(out_a_stb), 32'd1);
        chk("lat_bstb_e1", 32'(out_b_stb), 32'd0);
        chk("lat_out_a", out_a, 32'h40C0_0000);
        step();
        chk("lat_astb_e2", 32'(out_a_stb), 32'd0);
        chk("lat_bstb_e2", 32'(out_b_stb), 32'd1);
        chk("lat_out_b", out_b, 32'h4000_0000);
        step();
        chk("lat_bstb_e3", 32'(out_b_stb), 32'd0);
        chk("lat_cnt_e3", 32'(count), 32'd0);
        chk("lat_sent", 32'(pairs_sent), 32'd1);

        // Fill to DEPTH with acks low
        out_a_ack = 1'b0; out_b_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a = 32'hA000_0000 + 32'(i); in_b = 32'hB000_0000 + 32'(i); in_valid = 1'b1;
            step();
        end
        chk("fill_cnt", 32'(count), 32'd4);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_astb", 32'(out_a_stb), 32'd1);
        chk("fill_out_a", out_a, 32'hA000_0000);
        in_a = 32'hA000_0004; in_b = 32'hB000_0004;
        step(); step();
        chk("fill_blocked", 32'(count), 32'd4);
        out_a_ack = 1'b1;
        step();
        out_a_ack = 1'b0;
        chk("fill_bstb", 32'(out_b_stb), 32'd1);
        chk("fill_astb_off", 32'(out_a_stb), 32'd0);
        chk("fill_ready_a", 32'(in_ready), 32'd0);
        out_b_ack = 1'b1;
        step();
        out_b_ack = 1'b0;
        chk("fill_pop_cnt", 32'(count), 32'd3);
        chk("fill_pop_ready", 32'(in_ready), 32'd1);
        chk("fill_pop_sent", 32'(pairs_sent), 32'd2);
        chk("fill_chain_astb", 32'(out_a_stb), 32'd1);
        chk("fill_chain_a", out_a, 32'hA000_0001);
        step();
        in_valid = 1'b0;
        chk("fill_5th_cnt", 32'(count), 32'd4);
        for (int i = 1; i < 5; i++) begin
            exp_a.push_back(32'hA000_0000 + 32'(i));
            exp_b.push_back(32'hB000_0000 + 32'(i));
        end
        drain(4);
        chk("ord_cnt", 32'(count), 32'd0);
        chk("ord_sent", 32'(pairs_sent), 32'd6);

        // Simultaneous push and pop at count=2
        in_a = 32'hC000_0000; in_b = 32'hD000_0000; in_valid = 1'b1;
        step();
        in_a = 32'hC000_0001; in_b = 32'hD000_0001;
        step();
        in_valid = 1'b0;
        out_a_ack = 1'b1;
        step();
        out_a_ack = 1'b0;
        chk("pp_pre_cnt", 32'(count), 32'd2);
        chk("pp_pre_bstb", 32'(out_b_stb), 32'd1);
        in_a = 32'hC000_0002; in_b = 32'hD000_0002; in_valid = 1'b1; out_b_ack = 1'b1;
        step();
        in_valid = 1'b0; out_b_ack = 1'b0;
        chk("pp_cnt", 32'(count), 32'd2);
        chk("pp_sent", 32'(pairs_sent), 32'd7);
        chk("pp_astb", 32'(out_a_stb), 32'd1);
        chk("pp_out_a", out_a, 32'hC000_0001);
        exp_a.push_back(32'hC000_0001); exp_b.push_back(32'hD000_0001);
        exp_a.push_back(32'hC000_0002); exp_b.push_back(32'hD000_0002);
        drain(2);
        chk("pp_final_sent", 32'(pairs_sent), 32'd9);

        // Reset while in SEND_B with three pairs stored
        for (int i = 0; i < 3; i++) begin
            in_a = 32'hE000_0000 + 32'(i); in_b = 32'hF000_0000 + 32'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        out_a_ack = 1'b1;
        step();
        out_a_ack = 1'b0;
        chk("rs_pre_bstb", 32'(out_b_stb), 32'd1);
        chk("rs_pre_cnt", 32'(count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_cnt", 32'(count), 32'd0);
        chk("rs_astb", 32'(out_a_stb), 32'd0);
        chk("rs_bstb", 32'(out_b_stb), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_sent", 32'(pairs_sent), 32'd0);
        in_a = 32'h3F80_0000; in_b = 32'h0000_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_a.push_back(32'h3F80_0000); exp_b.push_back(32'h0000_0000);
        drain(1);
        chk("rs_after_sent", 32'(pairs_sent), 32'd1);
        chk("rs_after_cnt", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_div_operand_feeder.md
# fp_div_operand_feeder

Buffers single-precision divide requests and delivers them to the Newton-Raphson divider over its two-port strobe/acknowledge operand interface. It accepts one dividend/divisor pair per cycle on a valid/ready port and holds the pairs in a small FIFO. For each pair it presents operand A, then operand B, in the strict order the divider's get_a/get_b states require. It sits directly upstream of divider_newton, so that producers never stall on the divider's multi-cycle iteration.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in operand pairs; must be a power of 2, minimum 2.
- WIDTH, 32, operand width; fixed at IEEE-754 single precision.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- in_valid  in  1  pair offered.
- in_ready  out  1  FIFO not full; a pair is accepted when in_valid && in_ready at a rising edge.
- out_a  out  WIDTH  dividend to divider input_a.
- out_a_stb  out  1  to divider input_a_stb.
- out_a_ack  in  1  from divider input_a_ack.
- out_b  out  WIDTH  divisor to divider input_b.
- out_b_stb  out  1  to divider input_b_stb.
- out_b_ack  in  1  from divider input_b_ack.
- count  out  $clog2(DEPTH)+1  pairs currently stored, including the pair in flight.
- pairs_sent  out  16  pairs fully delivered since reset; wraps at 65535 -> 0.

## Operation
- Storage: a circular FIFO with head and tail pointers, each $clog2(DEPTH) bits wide and wrapping naturally.
  - Push: on acceptance, writes {in_a, in_b} at the tail.
  - Pop: occurs only when the B transfer completes.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on in_valid or a same-cycle pop.
- FSM states: IDLE, SEND_A, SEND_B.
- IDLE:
  - If count != 0: load out_a/out_b from the head entry, set out_a_stb=1, go to SEND_A.
- SEND_A:
  - Hold out_a_stb=1 and out_a stable.
  - On out_a_stb && out_a_ack: clear out_a_stb, set out_b_stb=1, go to SEND_B.
- SEND_B:
  - Hold out_b_stb=1.
  - On out_b_stb && out_b_ack: clear out_b_stb, pop, increment pairs_sent.
  - If (count - 1) != 0, load the next head entry, set out_a_stb=1, go to SEND_A; else go to IDLE.
- The strobes are never asserted together. B is never offered before the A transfer completes.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Full with a pop in progress: in_ready stays low during that cycle. The freed slot is visible the next cycle.
- There is no bypass. A pair pushed into an empty FIFO is not visible to the FSM until the following cycle.
- An ack arriving without the matching strobe high is ignored.

## Timing
- Reset values: state=IDLE, head=tail=0, count=0, out_a_stb=0, out_b_stb=0, out_a=0, out_b=0, pairs_sent=0, in_ready=1. FIFO contents are not reset.
- rst mid-operation:
  - All stored and in-flight pairs are discarded and the strobes drop at that edge.
  - The divider is reset by the same rst, so no partial pair survives on either side.
- Latency: push at edge N (empty, IDLE) -> out_a_stb=1 after edge N+1.
- With the divider's ack already high, A transfers at edge N+2 and out_b_stb=1 after N+2.
- Back-to-back pairs:
  - out_a_stb rises the cycle after the B transfer; there is no idle cycle.
  - The divider's own get_a ack re-assertion sets the actual rate.
- Strobes are registered and are cleared on the transfer edge. This matches the divider, which drops its ack one cycle after a transfer.

## Structure
- Shared package fp_div_pkg: WIDTH=32, FP_SINGLE_2=32'h4000_0000, FP_SINGLE_QNAN=32'hFFC0_0000, and the FSM state enum, so that divider and feeder share definitions.
- One sub-module, fp_operand_fifo:
  - A synchronous 2·WIDTH-wide FIFO with push/pop/full/empty/count.
  - The feeder FSM wraps it.

## Test plan
- Single pair in_a=0x40C00000 (6.0), in_b=0x40000000 (2.0), ack held high:
  - out_a_stb after edge 1, with out_a=0x40C00000.
  - out_b_stb after edge 2, with out_b=0x40000000.
  - count returns to 0 and pairs_sent=1.
- Fill: 5 consecutive in_valid pairs with ack held low:
  - in_ready drops after the 4th accept, and count=4.
  - The 5th pair is not accepted until the first B transfer frees a slot.
- Ordering: 3 queued pairs with ack toggling randomly:
  - Pairs are delivered in push order.
  - out_a_stb and out_b_stb are never high together.
  - Each operand is held stable while its strobe is high.
- Simultaneous push and pop at count=2: count stays 2, and the pushed data emerges third.
- Reset asserted in SEND_B with count=3: next cycle count=0, both strobes 0, in_ready=1; the following pair is delivered normally.
- Connected to divider_newton, 6.0/2.0 then 1.0/0.0: outputs 0x40400000, then 0x7F800000.
